arithmetic_logic_unit: RTL and testbench

ARITHMETIC_LOGIC_UNIT -- requirements
Module: arithmetic_logic_unit

---
 rtl/arithmetic_logic_unit_pkg.sv | 28 ++
 rtl/arithmetic_logic_unit_if.sv | 24 ++
 rtl/alu_compare.sv | 33 +++
 rtl/arithmetic_logic_unit.sv | 78 +++++++
 tb/tb_arithmetic_logic_unit.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/arithmetic_logic_unit_pkg.sv
// Shared constants for the ALU slice: default widths and operation codes.
// Operation code 0 and any value not listed below is treated as unrecognised.
package arithmetic_logic_unit_pkg;

  localparam int unsigned DefTypeBit     = 6;
  localparam int unsigned DefRobIndexBit = 4;

  typedef enum logic [DefTypeBit-1:0] {
    OpAdd  = 6'd1,
    OpSub  = 6'd2,
    OpSll  = 6'd3,
    OpSlt  = 6'd4,
    OpSltu = 6'd5,
    OpXor  = 6'd6,
    OpSrl  = 6'd7,
    OpSra  = 6'd8,
    OpOr   = 6'd9,
    OpAnd  = 6'd10,
    OpBeq  = 6'd11,
    OpBne  = 6'd12,
    OpBlt  = 6'd13,
    OpBge  = 6'd14,
    OpBltu = 6'd15,
    OpBgeu = 6'd16,
    OpJalr = 6'd17
  } alu_op_e;

endpackage

// File: rtl/arithmetic_logic_unit_if.sv
// Issue/result bundle between the dispatch stage (master) and the ALU (slave).
interface alu_if #(
  parameter int unsigned TYPE_BIT      = arithmetic_logic_unit_pkg::DefTypeBit,
  parameter int unsigned ROB_INDEX_BIT = arithmetic_logic_unit_pkg::DefRobIndexBit
);
  logic [TYPE_BIT-1:0]      inst_type;
  logic                     req;
  logic [31:0]              r1;
  logic [31:0]              r2;
  logic [ROB_INDEX_BIT-1:0] rob_id_in;
  logic                     ready;
  logic [ROB_INDEX_BIT-1:0] rob_id_out;
  logic [31:0]              result;

  modport master (
    output inst_type, req, r1, r2, rob_id_in,
    input  ready, rob_id_out, result
  );

  modport slave (
    input  inst_type, req, r1, r2, rob_id_in,
    output ready, rob_id_out, result
  );
endinterface

// File: rtl/alu_compare.sv
// Combinational comparator shared by set-less-than and branch-condition ops.
// Non-comparison op codes produce flag=0.
module alu_compare
  import arithmetic_logic_unit_pkg::*;
(
  input  logic [31:0]            r1,
  input  logic [31:0]            r2,
  input  logic [DefTypeBit-1:0]  op,
  output logic                   flag
);

  logic lt_s;
  logic lt_u;
  logic eq;

  assign lt_s = $signed(r1) < $signed(r2);
  assign lt_u = r1 < r2;
  assign eq   = r1 == r2;

  always_comb begin
    flag = 1'b0;
    case (op)
      OpSlt,  OpBlt:  flag = lt_s;
      OpSltu, OpBltu: flag = lt_u;
      OpBge:          flag = ~lt_s;
      OpBgeu:         flag = ~lt_u;
      OpBeq:          flag = eq;
      OpBne:          flag = ~eq;
      default:        flag = 1'b0;
    endcase
  end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Single-cycle pipelined integer ALU with registered result, tag and valid.
// Optional macro ALU_IDLE_ZERO_EN clears result/tag on idle edges instead of holding them.
module arithmetic_logic_unit
  import arithmetic_logic_unit_pkg::*;
#(
  parameter int unsigned TYPE_BIT      = DefTypeBit,
  parameter int unsigned ROB_INDEX_BIT = DefRobIndexBit
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  alu_if.slave bus
);

  logic                     ready_q;
  logic [31:0]              result_q;
  logic [31:0]              result_d;
  logic [ROB_INDEX_BIT-1:0] rob_id_q;
  logic                     cmp_flag;
  logic [31:0]              sum;
  logic [4:0]               shamt;

  assign sum   = bus.r1 + bus.r2;
  assign shamt = bus.r2[4:0];

  alu_compare u_compare (
    .r1   (bus.r1),
    .r2   (bus.r2),
    .op   (DefTypeBit'(bus.inst_type)),
    .flag (cmp_flag)
  );

  always_comb begin
    result_d = 32'd0;
    case (bus.inst_type)
      TYPE_BIT'(OpAdd):  result_d = sum;
      TYPE_BIT'(OpSub):  result_d = bus.r1 - bus.r2;
      TYPE_BIT'(OpXor):  result_d = bus.r1 ^ bus.r2;
      TYPE_BIT'(OpOr):   result_d = bus.r1 | bus.r2;
      TYPE_BIT'(OpAnd):  result_d = bus.r1 & bus.r2;
      TYPE_BIT'(OpSll):  result_d = bus.r1 << shamt;
      TYPE_BIT'(OpSrl):  result_d = bus.r1 >> shamt;
      TYPE_BIT'(OpSra):  result_d = $unsigned($signed(bus.r1) >>> shamt);
      TYPE_BIT'(OpJalr): result_d = {sum[31:1], 1'b0};
      TYPE_BIT'(OpSlt),  TYPE_BIT'(OpSltu),
      TYPE_BIT'(OpBeq),  TYPE_BIT'(OpBne),
      TYPE_BIT'(OpBlt),  TYPE_BIT'(OpBge),
      TYPE_BIT'(OpBltu), TYPE_BIT'(OpBgeu): result_d = {31'd0, cmp_flag};
      default:           result_d = 32'd0;
    endcase
  end

  // rdy_in low freezes everything, including ignoring req.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ready_q  <= 1'b0;
      result_q <= 32'd0;
      rob_id_q <= '0;
    end else if (rdy_in) begin
      if (bus.req) begin
        ready_q  <= 1'b1;
        result_q <= result_d;
        rob_id_q <= bus.rob_id_in;
      end else begin
        ready_q  <= 1'b0;
`ifdef ALU_IDLE_ZERO_EN
        result_q <= 32'd0;
        rob_id_q <= '0;
`endif
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.result     = result_q;
  assign bus.rob_id_out = rob_id_q;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// Directed scoreboard bench for arithmetic_logic_unit; expected results are hand-computed.
module tb_arithmetic_logic_unit;
  import arithmetic_logic_unit_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  rob;
  } exp_t;

  logic clk;
  logic rst;
  logic rdy;
  int   checks;
  int   errors;
  exp_t q[$];

  logic        m_ready;
  logic [31:0] m_result;
  logic [3:0]  m_rob;

  alu_if #(.TYPE_BIT(6), .ROB_INDEX_BIT(4)) bus ();

  arithmetic_logic_unit #(.TYPE_BIT(6), .ROB_INDEX_BIT(4)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".ready"}, {31'd0, bus.ready}, {31'd0, m_ready});
    chk({tag, ".result"}, bus.result, m_result);
    chk({tag, ".rob"}, {28'd0, bus.rob_id_out}, {28'd0, m_rob});
  endtask

  // Advance one edge, update the expected-output model from the scoreboard, then compare.
  task automatic tick(input string tag);
    exp_t e;
    logic smp_req;
    logic smp_rdy;
    smp_req = bus.req;
    smp_rdy = rdy;
    @(posedge clk);
    if (smp_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
      end else begin
        e = q.pop_front();
        if (smp_rdy) begin
          m_ready  = 1'b1;
          m_result = e.res;
          m_rob    = e.rob;
        end
      end
    end else if (smp_rdy) begin
      m_ready = 1'b0;
`ifdef ALU_IDLE_ZERO_EN
      m_result = 32'd0;
      m_rob    = 4'd0;
`endif
    end
    #1;
    chk_outputs(tag);
  endtask

  task automatic issue(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id, input logic [31:0] exp_res);
    exp_t e;
    bus.inst_type = op;
    bus.req       = 1'b1;
    bus.r1        = a;
    bus.r2        = b;
    bus.rob_id_in = id;
    e.res = exp_res;
    e.rob = id;
    q.push_back(e);
  endtask

  task automatic idle();
    bus.req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    rdy = 1'b1;
    bus.inst_type = '0;
    bus.req       = 1'b0;
    bus.r1        = '0;
    bus.r2        = '0;
    bus.rob_id_in = '0;
    m_ready  = 1'b0;
    m_result = 32'd0;
    m_rob    = 4'd0;

    #2;
    chk_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    issue(OpAdd, 32'd5, 32'd7, 4'd3, 32'd12);                  tick("add");
    idle();                                                    tick("idle_after_add");

    issue(OpSra, 32'h8000_0000, 32'h24, 4'd4, 32'hF800_0000);  tick("sra");
    issue(OpSrl, 32'h8000_0000, 32'h24, 4'd5, 32'h0800_0000);  tick("srl");
    issue(OpBlt, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd1);           tick("blt");
    issue(OpBltu, 32'hFFFF_FFFF, 32'd1, 4'd7, 32'd0);          tick("bltu");
    issue(OpBge, 32'hFFFF_FFFF, 32'd1, 4'd8, 32'd0);           tick("bge");
    issue(OpJalr, 32'h1001, 32'h4, 4'd9, 32'h1004);            tick("jalr");
    issue(OpSltu, 32'd0, 32'hFFFF_FFFF, 4'd10, 32'd1);         tick("sltu");
    issue(OpSub, 32'd3, 32'd5, 4'd11, 32'hFFFF_FFFE);          tick("sub");
    issue(OpXor, 32'hF0F0_00FF, 32'h0FF0_0F0F, 4'd12, 32'hFF00_0FF0); tick("xor");
    issue(OpOr, 32'hF000_0001, 32'h0000_0F00, 4'd13, 32'hF000_0F01);  tick("or");
    issue(OpAnd, 32'hFF00_FF00, 32'h0F0F_0F0F, 4'd14, 32'h0F00_0F00); tick("and");
    issue(OpSll, 32'd1, 32'd33, 4'd15, 32'd2);                 tick("sll");
    issue(OpSlt, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd1);           tick("slt");
    issue(OpBeq, 32'h1234, 32'h1234, 4'd1, 32'd1);             tick("beq");
    issue(OpBne, 32'h1234, 32'h1234, 4'd2, 32'd0);             tick("bne");
    issue(OpBgeu, 32'hFFFF_FFFF, 32'd1, 4'd3, 32'd1);          tick("bgeu");
    issue(OpAdd, 32'hFFFF_FFFF, 32'd2, 4'd4, 32'd1);           tick("add_wrap");
    bus.inst_type = 6'h3F;
    issue(OpAdd, 32'd9, 32'd9, 4'd5, 32'd0);
    bus.inst_type = 6'h3F;                                     tick("unknown_op");
    idle();                                                    tick("idle2");

    // Back-to-back tags with a frozen middle cycle.
    issue(OpAdd, 32'd1, 32'd0, 4'd1, 32'd1);                   tick("b2b_t1");
    rdy = 1'b0;
    issue(OpAdd, 32'd2, 32'd0, 4'd2, 32'd2);                   tick("b2b_frozen");
    rdy = 1'b1;
    issue(OpAdd, 32'd2, 32'd0, 4'd2, 32'd2);                   tick("b2b_t2");
    issue(OpAdd, 32'd3, 32'd0, 4'd3, 32'd3);                   tick("b2b_t3");
    rdy = 1'b0;
    idle();                                                    tick("frozen_idle");
    rdy = 1'b1;

    // Asynchronous reset between edges while ready is high.
    issue(OpXor, 32'hAAAA_AAAA, 32'h5555_5555, 4'd7, 32'hFFFF_FFFF); tick("pre_reset");
    idle();
    #2;
    rst = 1'b1;
    #1;
    m_ready  = 1'b0;
    m_result = 32'd0;
    m_rob    = 4'd0;
    chk_outputs("async_reset");
    #1;
    rst = 1'b0;
    tick("post_reset_idle");
    issue(OpAdd, 32'd5, 32'd7, 4'd3, 32'd12);                  tick("post_reset_add");
    idle();                                                    tick("final_idle");

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
